irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 149 ++++++++++++++
 tb/tb_irq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl -- edge-triggered interrupt controller with a single request in flight.
//
// Each external source is synchronized (two flops), rising-edge detected
// (third flop) and latched into a pending bit. Pending bits are set
// regardless of the mask. The masked pending vector is arbitrated with
// fixed priority (index 0 highest). One request is presented to the core
// at a time and tracked through IDLE -> REQ -> SERVICE.
//
// Ports:
//   clk         main clock, rising edge
//   rst         synchronous reset, active low
//   src         asynchronous interrupt lines, rising-edge sensitive
//   mask_wen    mask register write enable
//   mask_din    mask write data (1 = source enabled)
//   ir_ack      core acknowledge pulse (honoured only in REQ)
//   ir_done     handler-complete pulse (honoured only in SERVICE)
//   interrupter registered request to the core, high exactly in REQ
//   irq_id      index of the presented / serviced source, zero-extended
//   pending     pending register (unmasked)
//   mask        current mask register
//   busy        high in REQ or SERVICE
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             mask_wen,
  input  logic [N_SRC-1:0] mask_din,
  input  logic             ir_ack,
  input  logic             ir_done,
  output logic             interrupter,
  output logic [4:0]       irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [4:0]       r_irq_id;
  logic [4:0]       w_irq_id_next;
  logic             r_interrupter;
  logic             w_interrupter_next;

  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;
  logic [N_SRC-1:0] r_sync3;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;

  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_req_vec;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_pending_next;
  logic [4:0]       w_sel_id;
  logic             w_ack_take;

  assign w_edge     = r_sync2 & ~r_sync3;
  assign w_req_vec  = r_pending & r_mask;
  assign w_ack_take = (r_state == ST_REQ) && ir_ack;

  // Clear only the bit being acknowledged; a fresh edge on the same bit in
  // the same cycle is OR-ed in afterwards so the set wins.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_clr
      assign w_clr[gi] = w_ack_take && (r_irq_id == 5'(gi));
    end
  endgenerate

  assign w_pending_next = (r_pending & ~w_clr) | w_edge;

  // Fixed-priority pick: scan from the top so the lowest set index wins.
  always_comb begin
    w_sel_id = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_req_vec[i]) begin
        w_sel_id = 5'(i);
      end
    end
  end

  // Next-state logic. irq_id is only reloaded on IDLE -> REQ, so it stays
  // stable through REQ and SERVICE whatever the mask or pending bits do.
  always_comb begin
    w_state_next  = r_state;
    w_irq_id_next = r_irq_id;
    case (r_state)
      ST_IDLE: begin
        if (|w_req_vec) begin
          w_state_next  = ST_REQ;
          w_irq_id_next = w_sel_id;
        end
      end
      ST_REQ: begin
        if (ir_ack) begin
          w_state_next = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (ir_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_interrupter_next = (w_state_next == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_irq_id      <= 5'd0;
      r_interrupter <= 1'b0;
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_sync3       <= '0;
      r_pending     <= '0;
      r_mask        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_irq_id      <= w_irq_id_next;
      r_interrupter <= w_interrupter_next;
      r_sync1       <= src;
      r_sync2       <= r_sync1;
      r_sync3       <= r_sync2;
      r_pending     <= w_pending_next;
      if (mask_wen) begin
        r_mask <= mask_din;
      end
    end
  end

  assign interrupter = r_interrupter;
  assign irq_id      = r_irq_id;
  assign pending     = r_pending;
  assign mask        = r_mask;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: a per-cycle vector table (inputs plus expected
// outputs after the edge) and a grant scoreboard. Expected grant ids are
// queued when the causing stimulus is driven and checked when interrupter
// rises. A hand-written sequence then measures src-to-request latency.
module tb_irq_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] src = '0;
  logic         mask_wen = 1'b0;
  logic [N-1:0] mask_din = '0;
  logic         ir_ack = 1'b0;
  logic         ir_done = 1'b0;
  logic         interrupter;
  logic [4:0]   irq_id;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic         busy;

  irq_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .rst(rst), .src(src), .mask_wen(mask_wen), .mask_din(mask_din),
    .ir_ack(ir_ack), .ir_done(ir_done), .interrupter(interrupter),
    .irq_id(irq_id), .pending(pending), .mask(mask), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] src;
    logic         wen;
    logic [N-1:0] din;
    logic         ack;
    logic         done;
    logic [N-1:0] push;   // grant ids this stimulus is expected to cause
    logic         e_int;
    logic [4:0]   e_id;
    logic [N-1:0] e_pend;
    logic [N-1:0] e_mask;
    logic         e_busy;
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_int = 1'b0;

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [N-1:0] s, input logic w,
                     input logic [N-1:0] d, input logic a, input logic dn,
                     input logic [N-1:0] p, input logic ei, input logic [4:0] eid,
                     input logic [N-1:0] ep, input logic [N-1:0] em, input logic eb);
    vec_t v;
    v.rst = r; v.src = s; v.wen = w; v.din = d; v.ack = a; v.done = dn; v.push = p;
    v.e_int = ei; v.e_id = eid; v.e_pend = ep; v.e_mask = em; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [N-1:0] s, input logic w,
                       input logic [N-1:0] d, input logic a, input logic dn,
                       input logic [N-1:0] p);
    rst = r; src = s; mask_wen = w; mask_din = d; ir_ack = a; ir_done = dn;
    for (int b = 0; b < N; b++) begin
      if (p[b]) exp_q.push_back(b);
    end
  endtask

  // Advance one edge, sample 1 ns later, run the grant scoreboard.
  task automatic tick(input int row);
    int e;
    @(posedge clk);
    #1;
    if (interrupter === 1'b1 && prev_int !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL grant_unexpected row %0d: got irq_id %0d expected no request", row, irq_id);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", row, 32'(irq_id), 32'(e));
      end
    end
    prev_int = interrupter;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    //   rst src    wen din    ack dn push   int id pend   mask   busy
    add(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0); // 0 reset
    add(1, 8'h00, 1, 8'hFF, 0, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0); // 1 mask FF
    add(1, 8'h08, 0, 8'h00, 0, 0, 8'h08, 0, 0, 8'h00, 8'hFF, 0); // 2 src3 up (k)
    add(1, 8'h08, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0); // 3
    add(1, 8'h08, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h08, 8'hFF, 0); // 4 k+2 pending
    add(1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 3, 8'h08, 8'hFF, 1); // 5 k+3 request
    add(1, 8'h00, 0, 8'h00, 0, 1, 8'h00, 1, 3, 8'h08, 8'hFF, 1); // 6 done in REQ ignored
    add(1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 3, 8'h00, 8'hFF, 1); // 7 ack -> SERVICE
    add(1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 3, 8'h00, 8'hFF, 1); // 8 ack in SERVICE ignored
    add(1, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 3, 8'h00, 8'hFF, 0); // 9 done -> IDLE
    add(1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 3, 8'h00, 8'hFF, 0); // 10 ack in IDLE
    add(1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 3, 8'h00, 8'hFF, 0); // 11
    add(1, 8'h24, 0, 8'h00, 0, 0, 8'h24, 0, 3, 8'h00, 8'hFF, 0); // 12 src5,src2 up
    add(1, 8'h24, 0, 8'h00, 0, 0, 8'h00, 0, 3, 8'h00, 8'hFF, 0); // 13
    add(1, 8'h24, 0, 8'h00, 0, 0, 8'h00, 0, 3, 8'h24, 8'hFF, 0); // 14
    add(1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 2, 8'h24, 8'hFF, 1); // 15 id2, ack from IDLE ignored
    add(1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 2, 8'h20, 8'hFF, 1); // 16 ack
    add(1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 2, 8'h20, 8'hFF, 1); // 17 no nesting
    add(1, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 2, 8'h20, 8'hFF, 0); // 18 done
    add(1, 8'h00, 0, 8'h00, 0, 1, 8'h00, 1, 5, 8'h20, 8'hFF, 1); // 19 id5, done in IDLE ignored
    add(1, 8'h00, 1, 8'h00, 0, 0, 8'h00, 1, 5, 8'h20, 8'h00, 1); // 20 mask off, no withdrawal
    add(1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 5, 8'h00, 8'h00, 1); // 21 ack
    add(1, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 5, 8'h00, 8'h00, 0); // 22 done
    add(1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 5, 8'h00, 8'h00, 0); // 23
    add(1, 8'h01, 1, 8'hFE, 0, 0, 8'h01, 0, 5, 8'h00, 8'hFE, 0); // 24 mask FE, src0 up
    add(1, 8'h01, 0, 8'h00, 0, 0, 8'h00, 0, 5, 8'h00, 8'hFE, 0); // 25
    add(1, 8'h01, 0, 8'h00, 0, 0, 8'h00, 0, 5, 8'h01, 8'hFE, 0); // 26 pending despite mask
    add(1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 5, 8'h01, 8'hFE, 0); // 27 masked, idle
    add(1, 8'h00, 1, 8'hFF, 0, 0, 8'h00, 0, 5, 8'h01, 8'hFF, 0); // 28 mask FF
    add(1, 8'h00, 0, 8'h00, 0, 1, 8'h00, 1, 0, 8'h01, 8'hFF, 1); // 29 id0
    add(1, 8'h00, 0, 8'h00, 0, 1, 8'h00, 1, 0, 8'h01, 8'hFF, 1); // 30 done in REQ ignored
    add(1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 1); // 31 ack
    add(1, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00, 8'hFF, 0); // 32 done
    add(1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0); // 33
    add(1, 8'h02, 0, 8'h00, 0, 0, 8'h02, 0, 0, 8'h00, 8'hFF, 0); // 34 src1 up
    add(1, 8'h02, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0); // 35
    add(1, 8'h02, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h02, 8'hFF, 0); // 36
    add(1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h02, 8'hFF, 1); // 37 id1, src1 low
    add(1, 8'h02, 0, 8'h00, 0, 0, 8'h02, 1, 1, 8'h02, 8'hFF, 1); // 38 src1 up again
    add(1, 8'h02, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h02, 8'hFF, 1); // 39
    add(1, 8'h02, 0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h02, 8'hFF, 1); // 40 ack + edge: set wins
    add(1, 8'h02, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h02, 8'hFF, 1); // 41
    add(1, 8'h02, 0, 8'h00, 0, 1, 8'h00, 0, 1, 8'h02, 8'hFF, 0); // 42 done
    add(1, 8'h02, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h02, 8'hFF, 1); // 43 re-request id1
    add(1, 8'h02, 0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 1); // 44 ack
    add(1, 8'h02, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 1); // 45 held high: no re-set
    add(1, 8'h32, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 1); // 46 src5,src4 up
    add(1, 8'h32, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 1); // 47
    add(1, 8'h32, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h30, 8'hFF, 1); // 48 SERVICE, pending 30
    add(0, 8'h32, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0); // 49 reset aborts
    add(1, 8'h32, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0); // 50 release, src high
    add(1, 8'h32, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0); // 51
    add(1, 8'h32, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h32, 8'h00, 0); // 52 high-at-release sets once
    add(1, 8'h32, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h32, 8'h00, 0); // 53
    add(1, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h32, 8'h00, 0); // 54 ack in IDLE, no change
    add(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0); // 55 reset

    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].rst, vecs[r].src, vecs[r].wen, vecs[r].din, vecs[r].ack,
            vecs[r].done, vecs[r].push);
      tick(r);
      chk("interrupter", r, 32'(interrupter), 32'(vecs[r].e_int));
      chk("irq_id",      r, 32'(irq_id),      32'(vecs[r].e_id));
      chk("pending",     r, 32'(pending),     32'(vecs[r].e_pend));
      chk("mask",        r, 32'(mask),        32'(vecs[r].e_mask));
      chk("busy",        r, 32'(busy),        32'(vecs[r].e_busy));
      $display("row %0d: src=%h ack=%b done=%b -> int=%b id=%0d pend=%h mask=%h busy=%b",
               r, vecs[r].src, vecs[r].ack, vecs[r].done, interrupter, irq_id,
               pending, mask, busy);
    end

    // Latency: src rising sampled at edge k -> interrupter after edge k+3.
    drive(1, 8'h00, 1, 8'hFF, 0, 0, 8'h00);
    tick(100);
    drive(1, 8'h80, 0, 8'h00, 0, 0, 8'h80);
    tick(101);
    cnt = 0;
    while (interrupter !== 1'b1 && cnt < 20) begin
      tick(102 + cnt);
      cnt++;
    end
    chk("latency_edges", 101, 32'(cnt), 32'd3);
    $display("latency: interrupter after %0d edges past k, irq_id=%0d", cnt, irq_id);
    drive(1, 8'h80, 0, 8'h00, 1, 0, 8'h00);
    tick(130);
    chk("seq_ack_busy", 130, 32'(busy), 32'd1);
    chk("seq_ack_pend", 130, 32'(pending), 32'h00);
    drive(1, 8'h80, 0, 8'h00, 0, 1, 8'h00);
    tick(131);
    chk("seq_done_busy", 131, 32'(busy), 32'd0);
    $display("sequence done: busy=%b pending=%h", busy, pending);
    drive(1, 8'h80, 0, 8'h00, 0, 0, 8'h00);
    tick(132);
    chk("scoreboard_empty", 132, 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
